data_memory_param: RTL and testbench
====================================

DATA_MEMORY_PARAM -- requirements
Module: data_memory_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning log2 of depth in 32-bit words (256 words = 1 KiB).
REQ-002 SHALL have parameter LATENCY, default 4, meaning BUSY-state cycles per access, legal range 1..15.
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port read  input  4  [3]=enable, [2:0]=mode: 000 LW, 001 LB, 010 LH, 101 LBU, 110 LHU.
REQ-006 SHALL have port write  input  3  [2]=enable, [1:0]=size: 00 SW, 01 SB, 10 SH, 11 reserved no-op.
REQ-007 SHALL have port address  input  32  byte address.
REQ-008 SHALL have port writedata  input  32  store data; low byte/halfword used for SB/SH.
REQ-009 SHALL have port readdata  output  32  extended load result.
REQ-010 SHALL have port busywait  output  1  stall request to pipeline.
REQ-011 SHALL have port misaligned  output  1  alignment-fault flag.
REQ-012 SHALL have ports DEBUG_DATA (output 32), DEBUG_READ_ACC (output 1), DEBUG_WRITE_ACC (output 1), per REQ-030.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, ACK.
REQ-014 SHALL move IDLE->BUSY on a clock edge where read[3] or write[2] is 1; latch read, write, address, writedata at that edge.
REQ-015 SHALL stay in BUSY exactly LATENCY cycles using a 4-bit counter, then move BUSY->ACK at the edge that performs the access.
REQ-016 SHALL move ACK->IDLE unconditionally at the next edge; requests present during ACK are ignored.
REQ-017 SHALL drive busywait = (IDLE and request present) or BUSY; busywait 0 in ACK; a request therefore sees LATENCY+1 high cycles.
REQ-018 SHALL give read priority when read[3] and write[2] are both 1: perform load only.
REQ-019 SHALL index memory with address[ADDR_WIDTH+1:2]; higher address bits ignored (aliasing/wrap-around).
REQ-020 SHALL select byte lane address[1:0] and halfword lane address[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-021 SHALL update only addressed byte lanes on SB/SH; other lanes unchanged.
REQ-022 SHALL flag misaligned when LW/SW address[1:0]!=0 or LH/LHU/SH address[0]!=0; on fault: no memory write, readdata=0, misaligned=1.
REQ-023 SHALL hold readdata and misaligned stable from ACK entry until the next access completes; misaligned cleared at next IDLE->BUSY.
REQ-024 SHALL treat reserved read modes (011,100,111) as LW, and write size 11 as no-op that still completes the handshake.

Reset
REQ-025 SHALL on reset assertion immediately force state IDLE, counter 0, readdata 0, misaligned 0, debug outputs 0; busywait 0 while reset high.
REQ-026 SHALL abort any in-flight access on reset mid-BUSY with no memory write.
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL recognise macro DMEM_DEBUG_EN.
REQ-029 SHALL without DMEM_DEBUG_EN tie DEBUG_DATA, DEBUG_READ_ACC, DEBUG_WRITE_ACC to 0.
REQ-030 SHALL with DMEM_DEBUG_EN drive DEBUG_DATA = full 32-bit word at accessed index after the access, DEBUG_READ_ACC/DEBUG_WRITE_ACC = 1-cycle pulse in ACK for completed load/store (not on misaligned fault).

Verification
REQ-031 SHALL cover: SW 0xAABBCCDD @0x04, then LW @0x04 -> readdata 0xAABBCCDD; busywait high exactly 5 cycles per access (LATENCY=4).
REQ-032 SHALL cover: after REQ-031 store, LB @0x05 -> 0xFFFFFFCC; LBU @0x05 -> 0x000000CC; LH @0x06 -> 0xFFFFAABB.
REQ-033 SHALL cover: SW 0x11223344 @0x08, SH 0x1234 @0x0A, SB 0x55 @0x08 -> LW @0x08 = 0x12343355.
REQ-034 SHALL cover: LW @0x06 -> misaligned=1, readdata 0; SH 0xFFFF @0x03 -> misaligned=1, LW @0x00 unchanged.
REQ-035 SHALL cover: reset pulsed 2 cycles into SW 0xDEADBEEF @0x0C (old value 0) -> busywait 0 at once, later LW @0x0C = 0.
REQ-036 SHALL cover: SW 0xCAFEF00D @0x400 (ADDR_WIDTH=8) -> LW @0x000 = 0xCAFEF00D; with DMEM_DEBUG_EN, DEBUG_WRITE_ACC pulses once, DEBUG_DATA=0xCAFEF00D.

Source files
------------

// File: rtl/data_memory_param.sv
// data_memory_param: word RAM with byte/half/word loads and stores behind a fixed-latency
// busywait handshake. Define DMEM_DEBUG_EN to drive the DEBUG_* access taps.
module data_memory_param #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  read,
  input  logic [2:0]  write,
  input  logic [31:0] address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        busywait,
  output logic        misaligned,
  output logic [31:0] DEBUG_DATA,
  output logic        DEBUG_READ_ACC,
  output logic        DEBUG_WRITE_ACC
);
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  localparam int         DEPTH  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  rd_q;
  logic [2:0]  wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        mis_q;

  logic [31:0] mem [DEPTH];

  logic                  req;
  logic                  fire;
  logic                  is_ld;
  logic                  is_st;
  logic                  ld_mis;
  logic                  st_mis;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           word;
  logic [31:0]           ld_val;
  logic [31:0]           st_val;
  logic [7:0]            ld_b;
  logic [15:0]           ld_h;
  logic                  unused_addr;

  assign req   = read[3] | write[2];
  assign fire  = (state_q == BUSY) && (cnt_q == 4'd0);
  assign idx   = addr_q[ADDR_WIDTH+1:2];
  assign word  = mem[idx];
  // Loads win when both enables are latched together.
  assign is_ld = rd_q[3];
  assign is_st = !rd_q[3] && wr_q[2] && (wr_q[1:0] != 2'b11);
  assign unused_addr = ^addr_q[31:ADDR_WIDTH+2];

  always_comb begin
    ld_b = word[{addr_q[1:0], 3'b000} +: 8];
    ld_h = addr_q[1] ? word[31:16] : word[15:0];
    ld_val = word;
    ld_mis = |addr_q[1:0];
    unique case (rd_q[2:0])
      3'b001: begin ld_val = {{24{ld_b[7]}}, ld_b}; ld_mis = 1'b0; end
      3'b101: begin ld_val = {24'd0, ld_b};         ld_mis = 1'b0; end
      3'b010: begin ld_val = {{16{ld_h[15]}}, ld_h}; ld_mis = addr_q[0]; end
      3'b110: begin ld_val = {16'd0, ld_h};          ld_mis = addr_q[0]; end
      default: ;
    endcase
  end

  always_comb begin
    st_val = word;
    st_mis = 1'b0;
    unique case (wr_q[1:0])
      2'b00: begin
        st_val = wdata_q;
        st_mis = |addr_q[1:0];
      end
      2'b01: st_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b10: begin
        if (addr_q[1]) st_val[31:16] = wdata_q[15:0];
        else           st_val[15:0]  = wdata_q[15:0];
        st_mis = addr_q[0];
      end
      default: ;
    endcase
  end

  assign mem_we = fire && !reset && is_st && !st_mis;

  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= st_val;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 4'd0;
      wr_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (req) begin
          state_q <= BUSY;
          cnt_q   <= LAT_M1;
          rd_q    <= read;
          wr_q    <= write;
          addr_q  <= address;
          wdata_q <= writedata;
          mis_q   <= 1'b0;
        end
        BUSY: if (cnt_q == 4'd0) begin
          state_q <= ACK;
          if (is_ld) begin
            mis_q   <= ld_mis;
            rdata_q <= ld_mis ? 32'd0 : ld_val;
          end else if (is_st && st_mis) begin
            mis_q   <= 1'b1;
            rdata_q <= 32'd0;
          end
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign readdata   = rdata_q;
  assign misaligned = mis_q;
  assign busywait   = !reset && (((state_q == IDLE) && req) || (state_q == BUSY));

`ifdef DMEM_DEBUG_EN
  logic [31:0] dbg_data_q;
  logic        dbg_rd_q;
  logic        dbg_wr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dbg_data_q <= 32'd0;
      dbg_rd_q   <= 1'b0;
      dbg_wr_q   <= 1'b0;
    end else begin
      dbg_rd_q <= fire && is_ld && !ld_mis;
      dbg_wr_q <= fire && is_st && !st_mis;
      if (fire) dbg_data_q <= (is_st && !st_mis) ? st_val : word;
    end
  end

  assign DEBUG_DATA      = dbg_data_q;
  assign DEBUG_READ_ACC  = dbg_rd_q;
  assign DEBUG_WRITE_ACC = dbg_wr_q;
`else
  assign DEBUG_DATA      = 32'd0;
  assign DEBUG_READ_ACC  = 1'b0;
  assign DEBUG_WRITE_ACC = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_param.sv
// tb_data_memory_param: directed vector table plus reset, hold and aliasing
// sequences for data_memory_param (LATENCY=4, ADDR_WIDTH=8).
module tb_data_memory_param;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  read = 4'd0;
  logic [2:0]  write = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        busywait;
  logic        misaligned;
  logic [31:0] DEBUG_DATA;
  logic        DEBUG_READ_ACC;
  logic        DEBUG_WRITE_ACC;

  data_memory_param #(.ADDR_WIDTH(8), .LATENCY(4)) dut (
    .clock(clock), .reset(reset), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata),
    .busywait(busywait), .misaligned(misaligned),
    .DEBUG_DATA(DEBUG_DATA), .DEBUG_READ_ACC(DEBUG_READ_ACC),
    .DEBUG_WRITE_ACC(DEBUG_WRITE_ACC)
  );

  always #5 clock = ~clock;

  localparam logic [3:0] RN = 4'b0000, LW = 4'b1000, LB = 4'b1001,
    LH = 4'b1010, LBU = 4'b1101, LHU = 4'b1110, R3 = 4'b1011;
  localparam logic [2:0] WN = 3'b000, SW = 3'b100, SB = 3'b101,
    SH = 3'b110, SX = 3'b111;

  typedef struct packed {
    logic [3:0]  rd;
    logic [2:0]  wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        chk;
    logic        mis;
  } vec_t;

  vec_t vecs [25];
  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic access(input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int nb, output logic [31:0] rv,
                        output logic mv, output logic ra,
                        output logic wa, output logic [31:0] dd);
    @(posedge clock);
    #1;
    read = rd; write = wr; address = a; writedata = d;
    nb = 0;
    @(negedge clock);
    while (busywait === 1'b1 && nb < 40) begin
      nb++;
      @(negedge clock);
    end
    rv = readdata; mv = misaligned;
    ra = DEBUG_READ_ACC; wa = DEBUG_WRITE_ACC; dd = DEBUG_DATA;
    read = RN; write = WN;
    @(posedge clock);
    #1;
  endtask

  int          nb;
  logic [31:0] rv, dd;
  logic        mv, ra, wa;
  logic        era, ewa;

  initial begin
    vecs = '{
      '{WN[2:0] == 3'b0 ? RN : RN, SW, 32'h0C, 32'h0, 32'h0, 1'b0, 1'b0},
      '{RN,  SW, 32'h00, 32'h0BADF00D, 32'h0,        1'b0, 1'b0},
      '{RN,  SW, 32'h04, 32'hAABBCCDD, 32'h0,        1'b0, 1'b0},
      '{LW,  WN, 32'h04, 32'h0,        32'hAABBCCDD, 1'b1, 1'b0},
      '{LB,  WN, 32'h05, 32'h0,        32'hFFFFFFCC, 1'b1, 1'b0},
      '{LBU, WN, 32'h05, 32'h0,        32'h000000CC, 1'b1, 1'b0},
      '{LH,  WN, 32'h06, 32'h0,        32'hFFFFAABB, 1'b1, 1'b0},
      '{LHU, WN, 32'h06, 32'h0,        32'h0000AABB, 1'b1, 1'b0},
      '{RN,  SW, 32'h08, 32'h11223344, 32'h0,        1'b0, 1'b0},
      '{RN,  SH, 32'h0A, 32'h00001234, 32'h0,        1'b0, 1'b0},
      '{RN,  SB, 32'h08, 32'h00000055, 32'h0,        1'b0, 1'b0},
      '{LW,  WN, 32'h08, 32'h0,        32'h12343355, 1'b1, 1'b0},
      '{LB,  WN, 32'h0B, 32'h0,        32'h00000012, 1'b1, 1'b0},
      '{LH,  WN, 32'h08, 32'h0,        32'h00003355, 1'b1, 1'b0},
      '{LW,  WN, 32'h06, 32'h0,        32'h0,        1'b1, 1'b1},
      '{RN,  SH, 32'h03, 32'h0000FFFF, 32'h0,        1'b1, 1'b1},
      '{LW,  WN, 32'h00, 32'h0,        32'h0BADF00D, 1'b1, 1'b0},
      '{LW,  SW, 32'h00, 32'h99999999, 32'h0BADF00D, 1'b1, 1'b0},
      '{RN,  SX, 32'h00, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0},
      '{LW,  WN, 32'h00, 32'h0,        32'h0BADF00D, 1'b1, 1'b0},
      '{R3,  WN, 32'h04, 32'h0,        32'hAABBCCDD, 1'b1, 1'b0},
      '{LB,  WN, 32'h04, 32'h0,        32'hFFFFFFDD, 1'b1, 1'b0},
      '{LBU, WN, 32'h02, 32'h0,        32'h000000AD, 1'b1, 1'b0},
      '{RN,  SW, 32'h02, 32'h12345678, 32'h0,        1'b1, 1'b1},
      '{LW,  WN, 32'h00, 32'h0,        32'h0BADF00D, 1'b1, 1'b0}
    };

    // Reset state, with a request present during reset.
    #1 reset = 1'b1;
    read = LW;
    #1;
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_readdata", readdata, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    check("rst_dbg", {DEBUG_DATA[30:0], DEBUG_READ_ACC | DEBUG_WRITE_ACC}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    check("rst_busywait_held", {31'd0, busywait}, 32'd0);
    read = RN;
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 25; i++) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
             nb, rv, mv, ra, wa, dd);
      check($sformatf("v%0d_busy", i), nb, 32'd5);
      check($sformatf("v%0d_mis", i), {31'd0, mv}, {31'd0, vecs[i].mis});
      if (vecs[i].chk)
        check($sformatf("v%0d_rdata", i), rv, vecs[i].exp);
`ifdef DMEM_DEBUG_EN
      era = vecs[i].rd[3] && !vecs[i].mis;
      ewa = !vecs[i].rd[3] && vecs[i].wr[2] &&
            (vecs[i].wr[1:0] != 2'b11) && !vecs[i].mis;
`else
      era = 1'b0;
      ewa = 1'b0;
`endif
      check($sformatf("v%0d_dbg_acc", i), {30'd0, ra, wa}, {30'd0, era, ewa});
      check($sformatf("v%0d_dbg_pulse", i),
            {30'd0, DEBUG_READ_ACC, DEBUG_WRITE_ACC}, 32'd0);
    end

    // Misaligned flag and zeroed data stay put across idle cycles.
    access(LW, WN, 32'h06, 32'h0, nb, rv, mv, ra, wa, dd);
    repeat (3) @(posedge clock);
    #1;
    check("hold_mis", {31'd0, misaligned}, 32'd1);
    check("hold_rdata", readdata, 32'd0);
    access(LW, WN, 32'h04, 32'h0, nb, rv, mv, ra, wa, dd);
    check("mis_cleared", {31'd0, mv}, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("hold_rdata2", readdata, 32'hAABBCCDD);

    // Reset two cycles into a store aborts it.
    @(posedge clock);
    #1;
    read = RN; write = SW; address = 32'h0C; writedata = 32'hDEADBEEF;
    repeat (2) @(posedge clock);
    #1;
    check("abort_busy_before", {31'd0, busywait}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busywait}, 32'd0);
    check("abort_rdata", readdata, 32'd0);
    write = WN;
    @(negedge clock);
    reset = 1'b0;
    access(LW, WN, 32'h0C, 32'h0, nb, rv, mv, ra, wa, dd);
    check("abort_busycnt", nb, 32'd5);
    check("abort_mem", rv, 32'd0);

    // Upper address bits alias onto low words.
    access(RN, SW, 32'h400, 32'hCAFEF00D, nb, rv, mv, ra, wa, dd);
`ifdef DMEM_DEBUG_EN
    check("alias_dbg_wr", {31'd0, wa}, 32'd1);
    check("alias_dbg_data", dd, 32'hCAFEF00D);
`else
    check("alias_dbg_off", dd, 32'd0);
`endif
    check("alias_dbg_wr_done", {31'd0, DEBUG_WRITE_ACC}, 32'd0);
    access(LW, WN, 32'h000, 32'h0, nb, rv, mv, ra, wa, dd);
    check("alias_lw", rv, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
